// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg: opcodes, format codes and the pipeline entry type for the immediate-generation stage.
package rv_imm_pkg;
  localparam int XLEN_MAX = 64;
  localparam logic [6:0] OPCODE_LUI       = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL       = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR      = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD      = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE     = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPCODE_OP        = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_32     = 7'b0111011;
  localparam logic [6:0] OPCODE_FENCE     = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_SH = 3'd6;
  localparam logic [2:0] FMT_Z  = 3'd7;
  // XLEN-dependent fields are sized for RV64; RV32 instances use the low half
  typedef struct packed {
    logic [31:0]         ir;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    logic [2:0]          fmt;
    logic [11:0]         csr;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } entry_t;
endpackage

// File: rtl/rv_imm_gen_stage_decode.sv
// rv_imm_decode: combinational immediate, format, CSR address and illegal-opcode decode of one instruction.
module rv_imm_decode import rv_imm_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [11:0]     csr,
  output logic            illegal
);
  logic [6:0]  op;
  logic [31:0] imm32;
  logic [5:0]  shamt;
  logic        sh;
  assign op    = ir[6:0];
  assign sh    = ir[13:12] == 2'b01;
  assign shamt = XLEN == 64 ? ir[25:20] : {1'b0, ir[24:20]};
  // every zero-extended form has bit 31 clear, so one sign extension covers all
  assign imm   = XLEN'($signed(imm32));
  assign csr   = op == OPCODE_SYSTEM ? ir[31:20] : 12'd0;
  always_comb begin
    imm32   = {{20{ir[31]}}, ir[31:20]};
    fmt     = FMT_I;
    illegal = 1'b0;
    case (op)
      OPCODE_LUI, OPCODE_AUIPC: begin
        imm32 = {ir[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OPCODE_JAL: begin
        imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OPCODE_JALR, OPCODE_LOAD: ;
      OPCODE_STORE: begin
        imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        fmt   = FMT_S;
      end
      OPCODE_BRANCH: begin
        imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OPCODE_OP_IMM: begin
        imm32 = sh ? {26'd0, shamt} : imm32;
        fmt   = sh ? FMT_SH : FMT_I;
      end
      OPCODE_OP_IMM_32: begin
        illegal = XLEN == 32;
        imm32   = (sh && XLEN == 64) ? {27'd0, ir[24:20]} : imm32;
        fmt     = (sh && XLEN == 64) ? FMT_SH : FMT_I;
      end
      OPCODE_SYSTEM: begin
        imm32 = (ir[14] && ir[13:12] != 2'b00) ? {27'd0, ir[19:15]} : 32'd0;
        fmt   = (ir[14] && ir[13:12] != 2'b00) ? FMT_Z : FMT_I;
      end
      OPCODE_FENCE, OPCODE_OP, OPCODE_OP_32: begin
        imm32 = 32'd0;
        fmt   = FMT_R;
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv_imm_gen_stage.sv
// rv_imm_gen_stage: registered immediate-generation stage with PC-relative target and a skid buffer.
module rv_imm_gen_stage import rv_imm_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int EN_TARGET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ir,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [11:0]     out_csr,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);
  logic [XLEN-1:0] imm, target;
  logic [2:0]      fmt;
  logic [11:0]     csr;
  logic            illegal, skid_valid, accept, drain, pc_rel;
  entry_t          in_e, out_q, skid_q;
  rv_imm_decode #(.XLEN(XLEN)) u_dec (
    .ir(in_ir), .imm(imm), .fmt(fmt), .csr(csr), .illegal(illegal)
  );
  assign pc_rel   = in_ir[6:0] == OPCODE_JAL || in_ir[6:0] == OPCODE_BRANCH || in_ir[6:0] == OPCODE_AUIPC;
  assign target   = (EN_TARGET != 0 && pc_rel) ? in_pc + imm : '0;
  assign in_e     = '{ir: in_ir, pc: XLEN_MAX'(in_pc), imm: XLEN_MAX'(imm), fmt: fmt, csr: csr,
                      target: XLEN_MAX'(target), illegal: illegal};
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = ~out_valid | out_ready;
  // skid is only ever full while input is blocked, so draining it never coincides with an accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      out_valid  <= skid_valid | accept;
      out_q      <= skid_valid ? skid_q : accept ? in_e : out_q;
      skid_valid <= 1'b0;
    end else if (accept) begin
      skid_q     <= in_e;
      skid_valid <= 1'b1;
    end
  end
  assign out_ir      = out_q.ir;
  assign out_pc      = out_q.pc[XLEN-1:0];
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_csr     = out_q.csr;
  assign out_target  = out_q.target[XLEN-1:0];
  assign out_illegal = out_q.illegal;
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{out_q.pc[XLEN_MAX-1:XLEN], out_q.imm[XLEN_MAX-1:XLEN], out_q.target[XLEN_MAX-1:XLEN]};
  end
endmodule

// File: tb/tb_rv_imm_gen_stage.sv
// tb_rv_imm_gen_stage: directed checks of RV32 and RV64 instances driven in lockstep.
module tb_rv_imm_gen_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_ir = '0, pc32 = '0;
  logic [63:0] pc64 = '0;
  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] ir32, ir64, imm32, tgt32, opc32;
  logic [63:0] imm64, tgt64, opc64;
  logic [2:0]  fmt32, fmt64;
  logic [11:0] csr32, csr64;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rv_imm_gen_stage #(.XLEN(32), .EN_TARGET(1)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32), .in_ir(in_ir), .in_pc(pc32),
    .out_valid(vld32), .out_ready(out_ready), .out_ir(ir32), .out_pc(opc32), .out_imm(imm32), .out_fmt(fmt32),
    .out_csr(csr32), .out_target(tgt32), .out_illegal(ill32)
  );
  rv_imm_gen_stage #(.XLEN(64), .EN_TARGET(1)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64), .in_ir(in_ir), .in_pc(pc64),
    .out_valid(vld64), .out_ready(out_ready), .out_ir(ir64), .out_pc(opc64), .out_imm(imm64), .out_fmt(fmt64),
    .out_csr(csr64), .out_target(tgt64), .out_illegal(ill64)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [31:0] ir, input logic [63:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_ir    = ir;
    pc32     = pc[31:0];
    pc64     = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst vld32", vld32, 0);
    chk("rst imm32", imm32, 0);
    chk("rst imm64", imm64, 0);
    chk("rst rdy32", rdy32, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy32 after rst", rdy32, 1);
    chk("rdy64 after rst", rdy64, 1);
    issue(32'hFFF00093, 64'h0);
    chk("addi vld32", vld32, 1);
    chk("addi imm32", imm32, 64'hFFFFFFFF);
    chk("addi fmt32", fmt32, 1);
    chk("addi ill32", ill32, 0);
    chk("addi imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    issue(32'h4030D093, 64'h0);
    chk("srai imm32", imm32, 3);
    chk("srai fmt32", fmt32, 6);
    chk("srai imm64", imm64, 3);
    issue(32'h4230D093, 64'h0);
    chk("srai25 imm32", imm32, 3);
    chk("srai25 imm64", imm64, 64'h23);
    chk("srai25 fmt64", fmt64, 6);
    issue(32'hFFDFF06F, 64'h100);
    chk("jal imm32", imm32, 64'hFFFFFFFC);
    chk("jal tgt32", tgt32, 64'hFC);
    chk("jal fmt32", fmt32, 5);
    chk("jal pc32", opc32, 64'h100);
    issue(32'h00000463, 64'h2000);
    chk("beq imm32", imm32, 8);
    chk("beq tgt32", tgt32, 64'h2008);
    chk("beq fmt32", fmt32, 3);
    issue(32'hFFDFF06F, 64'h0);
    chk("jal wrap tgt32", tgt32, 64'hFFFFFFFC);
    chk("jal wrap tgt64", tgt64, 64'hFFFFFFFFFFFFFFFC);
    issue(32'h00001117, 64'h10);
    chk("auipc imm32", imm32, 64'h1000);
    chk("auipc tgt32", tgt32, 64'h1010);
    issue(32'hFE112E23, 64'h40);
    chk("sw imm32", imm32, 64'hFFFFFFFC);
    chk("sw fmt32", fmt32, 2);
    chk("sw tgt32", tgt32, 0);
    issue(32'h800002B7, 64'h40);
    chk("lui imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui imm32", imm32, 64'h80000000);
    chk("lui fmt64", fmt64, 4);
    chk("lui tgt64", tgt64, 0);
    issue(32'h3402D073, 64'h0);
    chk("csrrwi imm64", imm64, 5);
    chk("csrrwi csr64", csr64, 12'h340);
    chk("csrrwi fmt64", fmt64, 7);
    issue(32'h0000007F, 64'h0);
    chk("bad ill64", ill64, 1);
    chk("bad fmt64", fmt64, 1);
    chk("bad csr64", csr64, 0);
    issue(32'h0030909B, 64'h0);
    chk("slliw ill32", ill32, 1);
    chk("slliw ill64", ill64, 0);
    chk("slliw imm64", imm64, 3);
    chk("slliw fmt64", fmt64, 6);
    issue(32'h00208033, 64'h0);
    chk("add fmt32", fmt32, 0);
    chk("add imm32", imm32, 0);
    @(negedge clk);
    chk("idle vld32", vld32, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00100093;
    @(negedge clk);
    chk("bp A vld", vld32, 1);
    chk("bp A imm", imm32, 1);
    in_ir = 32'h00200093;
    @(negedge clk);
    chk("bp C blocked", rdy32, 0);
    chk("bp A held", imm32, 1);
    in_ir = 32'h00300093;
    @(negedge clk);
    chk("bp C still blocked", rdy32, 0);
    chk("bp A still held", ir32, 64'h00100093);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp B out", imm32, 2);
    chk("bp B vld", vld32, 1);
    chk("bp C ready", rdy32, 1);
    @(negedge clk);
    chk("bp C out", imm32, 3);
    chk("bp C vld", vld32, 1);
    chk("bp C out64", imm64, 3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp drained", vld32, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'h00400093;
    @(negedge clk);
    in_ir = 32'h00500093;
    @(negedge clk);
    chk("full rdy32", rdy32, 0);
    flush = 1'b1; out_ready = 1'b1; in_ir = 32'h00600093;
    @(negedge clk);
    chk("flush vld32", vld32, 0);
    chk("flush vld64", vld64, 0);
    chk("flush rdy32", rdy32, 1);
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush dropped", vld32, 0);
    out_ready = 1'b0; in_valid = 1'b1; in_ir = 32'hFFF00093;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-rst vld", vld32, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst vld", vld32, 0);
    chk("async rst imm", imm32, 0);
    chk("async rst ir", ir32, 0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    issue(32'h00700093, 64'h8);
    chk("resume imm32", imm32, 7);
    chk("resume pc32", opc32, 8);
    chk("resume vld64", vld64, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
